// File: rtl/warp_scheduler_if.sv
// Dispatcher/execution-side bus of warp_scheduler: block descriptor in, warp descriptors out.
// The scheduler uses the slave modport; the dispatcher and execution stage use master.
interface warp_scheduler_if #(
    parameter int WARP_SIZE = 32,
    parameter int MAX_WARPS = 8
);
    localparam int WID = (MAX_WARPS > 1) ? $clog2(MAX_WARPS) : 1;

    logic                 start;
    logic [31:0]          block_id;
    logic [31:0]          block_dim;
    logic [31:0]          num_threads;
    logic                 warp_valid;
    logic                 warp_ready;
    logic [WID-1:0]       warp_id;
    logic [31:0]          warp_base;
    logic [WARP_SIZE-1:0] warp_mask;
    logic                 warp_done;
    logic [WID-1:0]       warp_done_id;
    logic                 done;
    logic                 busy;
    logic                 err;

    modport slave (
        input  start, block_id, block_dim, num_threads, warp_ready, warp_done, warp_done_id,
        output warp_valid, warp_id, warp_base, warp_mask, done, busy, err
    );

    modport master (
        output start, block_id, block_dim, num_threads, warp_ready, warp_done, warp_done_id,
        input  warp_valid, warp_id, warp_base, warp_mask, done, busy, err
    );
endinterface

// File: rtl/warp_scheduler.sv
// Splits one thread block into warps, issues them in order and tracks completion.
// Optional macro WARP_SCHED_PERF_EN adds the perf_busy_cycles counter port.
module warp_scheduler #(
    parameter int WARP_SIZE = 32,
    parameter int MAX_WARPS = 8
) (
    input  logic              clk,
    input  logic              rst,
    warp_scheduler_if.slave   bus
`ifdef WARP_SCHED_PERF_EN
    ,
    output logic [31:0]       perf_busy_cycles
`endif
);
    localparam int WID  = (MAX_WARPS > 1) ? $clog2(MAX_WARPS) : 1;
    localparam int CNTW = WID + 1;
    localparam int LANE_SHIFT = $clog2(WARP_SIZE);
    localparam logic [31:0] WS32        = 32'(WARP_SIZE);
    localparam logic [31:0] MAXW32      = 32'(MAX_WARPS);
    localparam logic [31:0] MAX_THREADS = 32'(MAX_WARPS * WARP_SIZE);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ISSUE, S_WAIT, S_DONE} state_t;
    typedef logic [MAX_WARPS-1:0] wmap_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [31:0]          r_block_id;
    logic [31:0]          r_block_dim;
    logic [31:0]          r_num_threads;
    logic [CNTW-1:0]      r_nwarps;
    logic [31:0]          r_remain;
    logic [WID-1:0]       r_warp_id;
    logic [31:0]          r_base;
    logic [WARP_SIZE-1:0] r_mask;
    wmap_t                r_outstanding;
    logic                 r_err;

    logic [63:0]          w_block_start;
    logic [31:0]          w_tail;
    logic [31:0]          w_unclamped;
    logic [31:0]          w_active;
    logic [CNTW-1:0]      w_nwarps;
    logic                 w_accept;
    logic                 w_issue;
    logic                 w_transfer;
    logic                 w_last;
    logic [31:0]          w_remain_next;
    logic                 w_done_hit;
    wmap_t                w_set;
    wmap_t                w_clr;
    wmap_t                w_outstanding_next;

    function automatic logic [WARP_SIZE-1:0] lane_mask(input logic [31:0] remain);
        lane_mask = '0;
        for (int n = 0; n < WARP_SIZE; n++) begin
            lane_mask[n] = (32'(n) < remain);
        end
    endfunction

    // Product kept at 64 bits so a huge block_id*block_dim never wraps below num_threads.
    assign w_block_start = {32'b0, r_block_id} * {32'b0, r_block_dim};
    assign w_tail        = (w_block_start >= {32'b0, r_num_threads}) ? '0
                                                                     : r_num_threads - w_block_start[31:0];
    assign w_unclamped   = (r_block_dim < w_tail) ? r_block_dim : w_tail;
    assign w_active      = (w_unclamped > MAX_THREADS) ? MAX_THREADS : w_unclamped;
    assign w_nwarps      = CNTW'((w_active + WS32 - 32'd1) >> LANE_SHIFT);

    assign w_accept      = bus.start && !bus.block_id[31];
    assign w_issue       = (r_state == S_ISSUE);
    assign w_transfer    = w_issue && bus.warp_ready;
    assign w_last        = ({1'b0, r_warp_id} == (r_nwarps - CNTW'(1)));
    assign w_remain_next = (r_remain > WS32) ? (r_remain - WS32) : '0;

    // A done for a warp not yet outstanding (including the one issuing this cycle) is dropped.
    assign w_done_hit    = bus.warp_done && (32'(bus.warp_done_id) < MAXW32)
                           && r_outstanding[bus.warp_done_id];
    assign w_set         = w_transfer ? (wmap_t'(1) << r_warp_id) : '0;
    assign w_clr         = w_done_hit ? (wmap_t'(1) << bus.warp_done_id) : '0;
    assign w_outstanding_next = (r_outstanding | w_set) & ~w_clr;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // NOTE: every output and next-state value gets a default first so no path leaves a latch.
    always_comb begin
        w_state_next   = r_state;
        bus.warp_valid = 1'b0;
        bus.done       = 1'b0;
        bus.busy       = (r_state != S_IDLE);
        unique case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_SETUP;
            S_SETUP: w_state_next = (w_nwarps == '0) ? S_DONE : S_ISSUE;
            S_ISSUE: begin
                bus.warp_valid = 1'b1;
                if (w_transfer && w_last) begin
                    w_state_next = (w_outstanding_next == '0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT:  if (w_outstanding_next == '0) w_state_next = S_DONE;
            S_DONE: begin
                bus.done = 1'b1;
                if (!bus.start) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: synchronous reset clears the whole datapath, including the outstanding bitmap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_block_id    <= '0;
            r_block_dim   <= '0;
            r_num_threads <= '0;
            r_nwarps      <= '0;
            r_remain      <= '0;
            r_warp_id     <= '0;
            r_base        <= '0;
            r_mask        <= '0;
            r_outstanding <= '0;
            r_err         <= 1'b0;
        end else begin
            r_outstanding <= w_outstanding_next;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_block_id    <= bus.block_id;
                        r_block_dim   <= bus.block_dim;
                        r_num_threads <= bus.num_threads;
                    end
                end
                S_SETUP: begin
                    r_nwarps  <= w_nwarps;
                    r_remain  <= w_active;
                    r_warp_id <= '0;
                    r_base    <= w_block_start[31:0];
                    r_mask    <= lane_mask(w_active);
                    if (r_block_dim > MAX_THREADS) r_err <= 1'b1;
                end
                S_ISSUE: begin
                    if (w_transfer) begin
                        r_warp_id <= r_warp_id + WID'(1);
                        r_base    <= r_base + WS32;
                        r_remain  <= w_remain_next;
                        r_mask    <= lane_mask(w_remain_next);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.warp_id   = r_warp_id;
    assign bus.warp_base = r_base;
    assign bus.warp_mask = r_mask;
    assign bus.err       = r_err;

`ifdef WARP_SCHED_PERF_EN
    logic [31:0] r_perf_busy_cycles;

    always_ff @(posedge clk) begin
        if (rst)                    r_perf_busy_cycles <= '0;
        else if (r_state != S_IDLE) r_perf_busy_cycles <= r_perf_busy_cycles + 32'd1;
    end

    assign perf_busy_cycles = r_perf_busy_cycles;
`endif
endmodule

// File: doc/warp_scheduler.md
WARP_SCHEDULER -- requirements
Module: warp_scheduler

Interface
REQ-001 Parameter WARP_SIZE, default 32, threads per warp (power of two).
REQ-002 Parameter MAX_WARPS, default 8, max warps resident per block; WID = $clog2(MAX_WARPS).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset rst, synchronous, active-high.
REQ-005 start  input  1  block assigned, driven by the dispatcher's per-core start.
REQ-006 block_id  input  32  signed block index; -1 = invalid.
REQ-007 block_dim  input  32  threads per block.
REQ-008 num_threads  input  32  total kernel threads.
REQ-009 warp_valid  output  1  warp descriptor valid.
REQ-010 warp_ready  input  1  execution stage accepts the warp.
REQ-011 warp_id  output  WID  warp index within the block.
REQ-012 warp_base  output  32  global thread index of lane 0.
REQ-013 warp_mask  output  WARP_SIZE  active lanes; bit n = lane n.
REQ-014 warp_done  input  1  one warp finished.
REQ-015 warp_done_id  input  WID  id of the finished warp.
REQ-016 done  output  1  block finished; feeds the dispatcher's per-core done.
REQ-017 busy  output  1  state != IDLE.
REQ-018 err  output  1  sticky; block_dim > MAX_WARPS*WARP_SIZE.

Function
REQ-019 States SHALL be IDLE, SETUP, ISSUE, WAIT and DONE.
REQ-020 IDLE: start=1 with block_id >= 0 SHALL latch block_id, block_dim and num_threads and go to SETUP. start with block_id=-1 SHALL be ignored.
REQ-021 SETUP, 1 cycle: active = min(block_dim, num_threads - block_id*block_dim), clamped at 0 and at MAX_WARPS*WARP_SIZE. nwarps = ceil(active/WARP_SIZE). Go to ISSUE, or to DONE if nwarps=0.
REQ-022 Arithmetic SHALL be 32-bit unsigned after the sign check. The product block_id*block_dim SHALL be computed at 64 bits before the comparison.
REQ-023 Latency: the first warp_valid SHALL be asserted exactly 2 cycles after start is sampled in IDLE.
REQ-024 ISSUE: warps SHALL be issued in order id 0..nwarps-1. Each transfer occurs when warp_valid && warp_ready. One warp at most per cycle.
REQ-025 warp_base SHALL equal block_id*block_dim + warp_id*WARP_SIZE, truncated to 32 bits.
REQ-026 warp_mask bit n SHALL be 1 iff warp_id*WARP_SIZE + n < active.
REQ-027 While warp_valid=1 and warp_ready=0, warp_id, warp_base and warp_mask SHALL hold stable.
REQ-028 After the last transfer, the block SHALL go to WAIT.
REQ-029 An outstanding bitmap SHALL set bit k on transfer of warp k and clear bit k on warp_done with warp_done_id=k.
REQ-030 warp_done for an id that is not outstanding SHALL be ignored, including the same cycle as its own issue.
REQ-031 A transfer and a warp_done for a different id in the same cycle SHALL both take effect.
REQ-032 Completion: when all nwarps are issued and the bitmap is zero (in ISSUE or WAIT), the block SHALL go to DONE on the next cycle.
REQ-033 DONE: done=1. Go to IDLE when start=0; done SHALL fall in the same cycle the state becomes IDLE.
REQ-034 A new start SHALL NOT be accepted outside IDLE.
REQ-035 err SHALL be set in SETUP when clamping occurs. The clamped block SHALL still complete normally.

Reset
REQ-036 On rst, the block SHALL be in IDLE with warp_valid=0, warp_id=0, warp_base=0, warp_mask=0, done=0, busy=0, err=0, bitmap cleared and latched inputs zero.
REQ-037 rst asserted mid-block SHALL abandon the block immediately. Any later warp_done SHALL be ignored.

Configuration
REQ-038 Macro WARP_SCHED_PERF_EN defined: add output perf_busy_cycles (32 bits).
- Counts cycles with busy=1; wraps at 2^32.
- Cleared by rst.
- Counts across blocks.
REQ-039 Without WARP_SCHED_PERF_EN: the port and the counter SHALL be absent, with all other behaviour identical.

Verification
REQ-040 num_threads=100, block_dim=64, block_id=0, warp_ready=1 -> 2 warps: bases 0 and 32, masks 0xFFFFFFFF; first valid 2 cycles after start; done the cycle after the second warp_done.
REQ-041 Same config, block_id=1 -> warp0 base 64, mask 0xFFFFFFFF; warp1 base 96, mask 0x0000000F.
REQ-042 warp_ready=0 for 5 cycles during ISSUE -> warp_valid=1 with id, base and mask unchanged for all 5 cycles; single transfer on release.
REQ-043 warp_done id1 before id0, plus spurious warp_done id5 -> done only after both id0 and id1; id5 has no effect.
REQ-044 rst pulsed in WAIT -> next cycle all outputs at reset values; a following warp_done does not raise done.
REQ-045 block_id=-1 with start=1 -> stays IDLE, busy=0. Separately, block_dim=300, num_threads=300, block_id=0 -> err=1 and 8 full warps issued.
